// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding memory request,
// 2-entry {pc, inst} buffer towards decode, redirect flush/drop.
module ifetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_next_pc,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_e;

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              drop_q, drop_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] pc_mem_q [2];
  logic [DATA_W-1:0] inst_mem_q [2];
  logic              push, pop;

  // req_pc holds the address on the request channel so it stays
  // stable even when a redirect rewrites fetch_pc mid-request.
  assign req_valid   = (state_q == REQ);
  assign req_addr    = req_pc_q;
  assign out_valid   = (cnt_q != 2'd0);
  assign out_inst    = inst_mem_q[rd_q];
  assign out_pc      = pc_mem_q[rd_q];
  assign out_next_pc = pc_mem_q[rd_q] + INC;

  // Next-state, fetch address and buffer occupancy.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = 1'b0;
    push       = 1'b0;
    pop        = out_valid && out_ready;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (req_ready) begin
          pend_pc_d  = req_pc_q;
          fetch_pc_d = drop_q ? fetch_pc_q : req_pc_q + INC;
          state_d    = (drop_q || redirect_valid) ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          push    = !redirect_valid;
          state_d = REQ;
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (rsp_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) fetch_pc_d = redirect_pc;

    if (redirect_valid) cnt_d = 2'd0;
    else cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    // Full buffer with nothing outstanding: hold off fetching.
    if ((state_q == IDLE || push) && cnt_d == 2'd2) state_d = IDLE;

    if (state_q == REQ && state_d == REQ) drop_d = drop_q || redirect_valid;

    if (state_d == REQ && state_q != REQ) req_pc_d = fetch_pc_d;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      req_pc_q   <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
    end
  end

  // Two-entry buffer; a redirect flush wins over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_mem_q   <= '{default: '0};
      inst_mem_q <= '{default: '0};
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      if (push) begin
        pc_mem_q[wr_q]   <= pend_pc_q;
        inst_mem_q[wr_q] <= rsp_data;
      end
      if (redirect_valid) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end else begin
        if (push) wr_q <= ~wr_q;
        if (pop) rd_q <= ~rd_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: memory model pushes expected
// {pc, inst} per delivered response, output monitor pops/compares.
module tb_ifetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_next_pc;
  logic        out_ready;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   redir_cnt = 0;
  int   rst_epoch = 0;
  int   mem_lat = 1;
  int   n_out = 0;

  ifetch_ctrl dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .out_valid(out_valid),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .out_next_pc(out_next_pc),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Redirects seen by the design flush everything expected so far.
  initial forever begin
    @(posedge clk);
    if (rst && redirect_valid) begin
      redir_cnt++;
      exp_q.delete();
    end
  end

  initial forever begin
    @(negedge rst);
    rst_epoch++;
    exp_q.delete();
  end

  // Memory model: latency mem_lat, data = addr ^ 32'hFFFF_FFFF.
  initial begin : mem_model
    logic [31:0] a;
    int snap, ep, lat, hold;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst && req_valid) begin
        a = req_addr; snap = redir_cnt; ep = rst_epoch;
        lat = mem_lat; hold = 0;
        while (rst && !req_ready && ep == rst_epoch && hold < 200) begin
          @(negedge clk);
          hold++;
          if (rst && ep == rst_epoch) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== a) begin
              fails++;
              $display("FAIL req_stable: valid=%b addr=%h, required valid=1 addr=%h",
                       req_valid, req_addr, a);
            end
          end
        end
        if (hold >= 200) begin
          fails++;
          $display("FAIL req_accept_timeout: addr=%h never accepted", a);
        end
        if (rst && ep == rst_epoch) begin
          @(posedge clk);
          for (int i = 1; i < lat && ep == rst_epoch; i++) @(posedge clk);
          if (ep == rst_epoch) begin
            #1;
            rsp_valid = 1'b1;
            rsp_data  = a ^ 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            rsp_valid = 1'b0;
            if (ep == rst_epoch && redir_cnt == snap)
              exp_q.push_back('{pc: a, inst: a ^ 32'hFFFF_FFFF});
          end
        end
      end
    end
  end

  // Output scoreboard: compare each consumed head.
  initial forever begin : out_mon
    exp_t e;
    @(negedge clk);
    if (rst && out_valid && out_ready) begin
      checks++;
      n_out++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: pc=%h inst=%h, required no output",
                 out_pc, out_inst);
      end else begin
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_inst !== e.inst ||
            out_next_pc !== e.pc + 32'd4) begin
          fails++;
          $display("FAIL out_entry: pc=%h inst=%h next=%h, required %h %h %h",
                   out_pc, out_inst, out_next_pc, e.pc, e.inst, e.pc + 32'd4);
        end
      end
    end
  end

  // A push into a full buffer must never happen.
  initial forever begin
    @(negedge clk);
    if (rst && dut.push) begin
      checks++;
      if (dut.cnt_q == 2'd2) begin
        fails++;
        $display("FAIL push_full: push with count=%0d, required count<2", dut.cnt_q);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (req_valid !== 1'b0 || req_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_req: valid=%b addr=%h, required 0 00000000", req_valid, req_addr);
    end
    checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pc !== 32'h0 ||
        out_next_pc !== 32'h4) begin
      fails++;
      $display("FAIL reset_out: v=%b inst=%h pc=%h next=%h, required 0 0 0 4",
               out_valid, out_inst, out_pc, out_next_pc);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stream();
    logic ev;
    logic [31:0] ea;
    for (int c = 1; c <= 12; c++) begin
      tick();
      ev = (c % 2 == 1);
      ea = 32'(4 * ((c - 1) / 2));
      checks++;
      if (req_valid !== ev || (ev && req_addr !== ea)) begin
        fails++;
        $display("FAIL stream_req c=%0d: valid=%b addr=%h, required %b %h",
                 c, req_valid, req_addr, ev, ea);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] nxt;
    int i;
    out_ready = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c >= 7) begin
        checks++;
        if (req_valid !== 1'b0 || out_valid !== 1'b1) begin
          fails++;
          $display("FAIL full_hold c=%0d: req_valid=%b out_valid=%b, required 0 1",
                   c, req_valid, out_valid);
        end
      end
    end
    checks++;
    if (exp_q.size() != 2) begin
      fails++;
      $display("FAIL full_count: buffered=%0d, required 2", exp_q.size());
    end
    nxt = (exp_q.size() > 0) ? exp_q[$].pc + 32'd4 : 32'h0;
    out_ready = 1'b1;
    for (i = 0; i < 20 && !req_valid; i++) tick();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== nxt) begin
      fails++;
      $display("FAIL resume_req: valid=%b addr=%h, required 1 %h", req_valid, req_addr, nxt);
    end
  endtask

  task automatic test_redirect_wait();
    int i;
    mem_lat = 3;
    for (i = 0; i < 20 && req_valid; i++) tick();
    for (i = 0; i < 20 && !req_valid; i++) tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || req_valid !== 1'b0) begin
      fails++;
      $display("FAIL rdw_flush: out_valid=%b req_valid=%b, required 0 0", out_valid, req_valid);
    end
    tick();
    checks++;
    if (req_valid !== 1'b0) begin
      fails++;
      $display("FAIL rdw_drop: req_valid=%b, required 0", req_valid);
    end
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h100) begin
      fails++;
      $display("FAIL rdw_req: valid=%b addr=%h, required 1 00000100", req_valid, req_addr);
    end
    mem_lat = 1;
    for (i = 0; i < 20 && !out_valid; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'hFFFF_FEFF) begin
      fails++;
      $display("FAIL rdw_first: v=%b pc=%h inst=%h, required 1 00000100 fffffeff",
               out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_redirect_rsp_pop();
    int i;
    out_ready = 1'b0;
    for (i = 0; i < 20 && !(rsp_valid && out_valid); i++) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h200) begin
      fails++;
      $display("FAIL rrp: out_valid=%b req_valid=%b addr=%h, required 0 1 00000200",
               out_valid, req_valid, req_addr);
    end
    for (i = 0; i < 20 && !out_valid; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      fails++;
      $display("FAIL rrp_first: v=%b pc=%h, required 1 00000200", out_valid, out_pc);
    end
  endtask

  task automatic test_req_hold();
    logic [31:0] a;
    int i;
    req_ready = 1'b0;
    for (i = 0; i < 20 && !req_valid; i++) tick();
    a = req_addr;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    for (int c = 0; c < 3; c++) begin
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (req_valid !== 1'b1 || req_addr !== a) begin
        fails++;
        $display("FAIL hold_req c=%0d: valid=%b addr=%h, required 1 %h",
                 c, req_valid, req_addr, a);
      end
    end
    req_ready = 1'b1;
    tick();
    checks++;
    if (req_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_drop: req_valid=%b, required 0", req_valid);
    end
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h300) begin
      fails++;
      $display("FAIL hold_new: valid=%b addr=%h, required 1 00000300", req_valid, req_addr);
    end
    for (i = 0; i < 20 && !out_valid; i++) tick();
    checks++;
    if (out_pc !== 32'h300) begin
      fails++;
      $display("FAIL hold_first: pc=%h, required 00000300", out_pc);
    end
  endtask

  task automatic test_wrap();
    int i;
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    for (i = 0; i < 20 && !(req_valid && req_addr == 32'hFFFF_FFFC); i++) tick();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL wrap_first: valid=%b addr=%h, required 1 fffffffc", req_valid, req_addr);
    end
    for (i = 0; i < 20 && req_valid; i++) tick();
    for (i = 0; i < 20 && !req_valid; i++) tick();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
      fails++;
      $display("FAIL wrap_req: valid=%b addr=%h, required 1 00000000", req_valid, req_addr);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_next_pc !== 32'h0 ||
        out_inst !== 32'h3) begin
      fails++;
      $display("FAIL wrap_out: v=%b pc=%h next=%h inst=%h, required 1 fffffffc 0 3",
               out_valid, out_pc, out_next_pc, out_inst);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    int i;
    mem_lat = 4;
    for (i = 0; i < 20 && !req_valid; i++) tick();
    tick();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b0 || req_addr !== 32'h0 || out_valid !== 1'b0 ||
        out_inst !== 32'h0 || out_pc !== 32'h0 || out_next_pc !== 32'h4) begin
      fails++;
      $display("FAIL async_rst: rv=%b ra=%h ov=%b oi=%h op=%h on=%h, required 0 0 0 0 0 4",
               req_valid, req_addr, out_valid, out_inst, out_pc, out_next_pc);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    mem_lat = 1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_restart: valid=%b addr=%h, required 1 00000000", req_valid, req_addr);
    end
    repeat (8) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    req_ready = 1'b1;
    out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp_pop();
    test_req_hold();
    test_wrap();
    test_async_reset();
    req_ready = 1'b0;
    repeat (10) tick();
    checks++;
    if (exp_q.size() != 0 || n_out < 10) begin
      fails++;
      $display("FAIL drain: pending=%0d consumed=%0d, required 0 and >=10",
               exp_q.size(), n_out);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
